// File: rtl/axis_arb_pkg.sv
// axis_arb_pkg: shared state type and rotate-priority pick helper for AXIS arbiters
package axis_arb_pkg;
    typedef enum logic {ARB, XFER} arb_state_t;
    // first set bit searching ptr+1, ptr+2, ... modulo n; returns ptr when none is set
    function automatic int rr_next(input logic [31:0] valid, input int ptr, input int n);
        int idx;
        rr_next = ptr;
        for (int i = n; i >= 1; i--) begin
            idx = ptr + i;
            if (idx >= n) idx -= n;
            if (valid[idx[4:0]]) rr_next = idx;
        end
    endfunction
endpackage

// File: rtl/axis_rr_pick.sv
// axis_rr_pick: combinational round-robin picker over a request vector
module axis_rr_pick
    import axis_arb_pkg::*;
#(
    parameter int N_PORTS = 4,
    localparam int ID_WIDTH = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
    input  logic [N_PORTS-1:0]  valid_i,
    input  logic [ID_WIDTH-1:0] ptr_i,
    output logic [ID_WIDTH-1:0] grant_idx_o,
    output logic                any_o
);
    assign any_o = |valid_i;
    assign grant_idx_o = ID_WIDTH'(rr_next(32'(valid_i), int'(ptr_i), N_PORTS));
endmodule

// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: N-to-1 AXI4-Stream round-robin arbiter, packet/burst grants, registered output
module axis_rr_arbiter
    import axis_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int N_PORTS = 4,
    parameter int MAX_BURST = 16,
    localparam int ID_WIDTH = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
    input  logic                            clk_i,
    input  logic                            arstn_i,
    input  logic [N_PORTS*DATA_WIDTH-1:0]   s_axis_tdata_i,
    input  logic [N_PORTS-1:0]              s_axis_tvalid_i,
    input  logic [N_PORTS-1:0]              s_axis_tlast_i,
    output logic [N_PORTS-1:0]              s_axis_tready_o,
    output logic [DATA_WIDTH-1:0]           m_axis_tdata_o,
    output logic                            m_axis_tlast_o,
    output logic [ID_WIDTH-1:0]             m_axis_tid_o,
    output logic                            m_axis_tvalid_o,
    input  logic                            m_axis_tready_i
);
    localparam int CW = $clog2(MAX_BURST + 1);

    arb_state_t state, state_next;
    logic [ID_WIDTH-1:0] grant, rr_ptr, win;
    logic [CW-1:0] beat_cnt;
    logic any, open, accept, release_grant;

    axis_rr_pick #(.N_PORTS(N_PORTS)) u_pick (
        .valid_i     (s_axis_tvalid_i),
        .ptr_i       (rr_ptr),
        .grant_idx_o (win),
        .any_o       (any)
    );

    // the output slot is free when empty or being drained this cycle
    assign open = (state == XFER) & (~m_axis_tvalid_o | m_axis_tready_i);
    assign accept = open & s_axis_tvalid_i[grant];
    assign release_grant = s_axis_tlast_i[grant] | (beat_cnt == CW'(MAX_BURST - 1));
    assign s_axis_tready_o = open ? N_PORTS'(1) << grant : '0;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) state <= ARB;
        else state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (state == ARB) state_next = any ? XFER : ARB;
        else if (accept & release_grant) state_next = ARB;
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            grant <= '0;
            rr_ptr <= ID_WIDTH'(N_PORTS - 1);
            beat_cnt <= '0;
            m_axis_tdata_o <= '0;
            m_axis_tlast_o <= 1'b0;
            m_axis_tid_o <= '0;
            m_axis_tvalid_o <= 1'b0;
        end else begin
            if (state == ARB && any) begin
                grant <= win;
                rr_ptr <= win;
                beat_cnt <= '0;
            end else if (accept) begin
                beat_cnt <= release_grant ? '0 : beat_cnt + 1'b1;
            end
            if (accept) begin
                m_axis_tdata_o <= s_axis_tdata_i[grant*DATA_WIDTH +: DATA_WIDTH];
                m_axis_tlast_o <= s_axis_tlast_i[grant];
                m_axis_tid_o <= grant;
                m_axis_tvalid_o <= 1'b1;
            end else if (m_axis_tready_i) begin
                m_axis_tvalid_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_axis_rr_arbiter.sv
// tb_axis_rr_arbiter: directed and random traffic against a behavioural arbiter model
module tb_axis_rr_arbiter;
    localparam int DW = 32, NP = 4, MB = 16, IW = 2;

    logic clk_i = 1'b0, arstn_i = 1'b0;
    logic [NP*DW-1:0] s_axis_tdata_i;
    logic [NP-1:0] s_axis_tvalid_i, s_axis_tlast_i, s_axis_tready_o;
    logic [DW-1:0] m_axis_tdata_o;
    logic m_axis_tlast_o, m_axis_tvalid_o, m_axis_tready_i;
    logic [IW-1:0] m_axis_tid_o;

    axis_rr_arbiter #(.DATA_WIDTH(DW), .N_PORTS(NP), .MAX_BURST(MB)) dut (
        .clk_i           (clk_i),
        .arstn_i         (arstn_i),
        .s_axis_tdata_i  (s_axis_tdata_i),
        .s_axis_tvalid_i (s_axis_tvalid_i),
        .s_axis_tlast_i  (s_axis_tlast_i),
        .s_axis_tready_o (s_axis_tready_o),
        .m_axis_tdata_o  (m_axis_tdata_o),
        .m_axis_tlast_o  (m_axis_tlast_o),
        .m_axis_tid_o    (m_axis_tid_o),
        .m_axis_tvalid_o (m_axis_tvalid_o),
        .m_axis_tready_i (m_axis_tready_i)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0, errors = 0;
    int cyc, ready_mode, gen_total;
    bit rand_valid;
    logic [DW:0] src_q[NP][$];
    int gen_seq[NP], next_seq[NP], start_at[NP];
    bit present[NP];
    int out_tid[$], out_cyc[$];
    bit m_arb, m_ov;
    int m_win, m_cnt;
    logic [IW+DW:0] m_reg;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int pick(input logic [NP-1:0] v, input int last);
        for (int d = 1; d <= NP; d++) if (v[(last + d) % NP]) return (last + d) % NP;
        return last;
    endfunction

    task automatic load(input int k, input int len, input bit nolast);
        for (int i = 0; i < len; i++) begin
            src_q[k].push_back({!nolast && i == len - 1, 8'(k), 24'(gen_seq[k])});
            gen_seq[k]++;
        end
    endtask

    task automatic do_reset();
        arstn_i = 1'b0;
        s_axis_tvalid_i = '0;
        s_axis_tlast_i = '0;
        s_axis_tdata_i = '0;
        m_axis_tready_i = 1'b0;
        for (int k = 0; k < NP; k++) begin
            src_q[k].delete();
            gen_seq[k] = 0;
            next_seq[k] = 0;
            start_at[k] = 0;
            present[k] = 0;
        end
        out_tid.delete();
        out_cyc.delete();
        m_arb = 1; m_ov = 0; m_win = NP - 1; m_cnt = 0; m_reg = '0;
        rand_valid = 0; ready_mode = 0; cyc = 0;
        repeat (2) @(posedge clk_i);
        #1 arstn_i = 1'b1;
    endtask

    task automatic step();
        logic [DW:0] beat;
        logic [NP-1:0] er;
        bit acc;
        for (int k = 0; k < NP; k++) begin
            if (!present[k] && src_q[k].size() > 0 && cyc >= start_at[k] &&
                (!rand_valid || $urandom_range(3) != 0)) present[k] = 1;
            beat = present[k] ? src_q[k][0] : '0;
            s_axis_tvalid_i[k] = present[k];
            s_axis_tlast_i[k] = beat[DW];
            s_axis_tdata_i[k*DW +: DW] = beat[DW-1:0];
        end
        m_axis_tready_i = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? (cyc % 2 == 0) : ($urandom_range(3) != 0);
        @(negedge clk_i);
        er = '0;
        if (!m_arb && (!m_ov || m_axis_tready_i)) er[m_win] = 1'b1;
        check("s_ready", s_axis_tready_o, er);
        check("onehot", $onehot0(s_axis_tready_o), 1);
        check("m_valid", m_axis_tvalid_o, m_ov);
        if (m_ov) check("m_beat", {m_axis_tid_o, m_axis_tlast_o, m_axis_tdata_o}, m_reg);
        if (m_ov && m_axis_tready_i) begin
            out_tid.push_back(int'(m_axis_tid_o));
            out_cyc.push_back(cyc);
            check("order", m_axis_tdata_o[23:0], next_seq[m_axis_tid_o]);
            next_seq[m_axis_tid_o]++;
        end
        acc = !m_arb && (!m_ov || m_axis_tready_i) && s_axis_tvalid_i[m_win];
        if (m_arb) begin
            if (|s_axis_tvalid_i) begin
                m_win = pick(s_axis_tvalid_i, m_win);
                m_arb = 0;
                m_cnt = 0;
            end
        end else if (acc) begin
            beat = src_q[m_win].pop_front();
            present[m_win] = 0;
            m_reg = {IW'(m_win), beat};
            m_cnt++;
            if (beat[DW] || m_cnt == MB) m_arb = 1;
        end
        m_ov = acc ? 1 : (m_axis_tready_i ? 0 : m_ov);
        @(posedge clk_i);
        #1 cyc++;
    endtask

    task automatic run_until(input int n, input int budget);
        for (int c = 0; c < budget && out_tid.size() < n; c++) step();
        check("beats", out_tid.size(), n);
    endtask

    initial begin
        do_reset();
        load(0, 10, 0);
        repeat (4) step();
        #2 arstn_i = 1'b0;
        #1;
        check("rst_m_valid", m_axis_tvalid_o, 0);
        check("rst_m_data", m_axis_tdata_o, 0);
        check("rst_m_last", m_axis_tlast_o, 0);
        check("rst_m_tid", m_axis_tid_o, 0);
        check("rst_s_ready", s_axis_tready_o, 0);

        do_reset();
        for (int k = 0; k < NP; k++) load(k, 2, 0);
        run_until(8, 100);
        for (int i = 0; i < out_tid.size(); i++) begin
            check("rr_tid", out_tid[i], i / 2);
            if (i > 0) check("rr_gap", out_cyc[i] - out_cyc[i-1], (i % 2 == 1) ? 1 : 2);
        end

        do_reset();
        load(2, 40, 1);
        load(1, 2, 0);
        start_at[1] = 3;
        run_until(42, 200);
        for (int i = 0; i < out_tid.size(); i++)
            check("burst_tid", out_tid[i], (i >= 16 && i < 18) ? 1 : 2);

        do_reset();
        load(0, 5, 0);
        ready_mode = 1;
        run_until(5, 100);
        for (int i = 0; i < out_tid.size(); i++) check("bp_tid", out_tid[i], 0);

        do_reset();
        repeat (3) load(3, 1, 0);
        run_until(3, 50);
        for (int i = 0; i < out_tid.size(); i++) begin
            check("solo_tid", out_tid[i], 3);
            if (i > 0) check("solo_gap", out_cyc[i] - out_cyc[i-1], 2);
        end

        do_reset();
        rand_valid = 1;
        ready_mode = 2;
        gen_total = 0;
        for (int c = 0; c < 40000 && out_tid.size() < 10000; c++) begin
            for (int k = 0; k < NP; k++) begin
                if (src_q[k].size() < 4 && gen_total < 10000) begin
                    int len = $urandom_range(1, 24);
                    if (len > 10000 - gen_total) len = 10000 - gen_total;
                    load(k, len, 0);
                    gen_total += len;
                end
            end
            step();
        end
        check("rand_beats", out_tid.size(), 10000);
        for (int k = 0; k < NP; k++) check("rand_drained", src_q[k].size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
